// File: rtl/det_event_monitor_if.sv
// Bundle between the pattern detector side and the event monitor: detector hit
// and control inputs in, per-frame and running statistics out.
interface det_event_monitor_if #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned TW        = 16
);
  localparam int unsigned CW = $clog2(FRAME_LEN + 1);

  logic          en;
  logic          hit;
  logic          clr_alarm;
  logic          frame_done;
  logic [CW-1:0] frame_count;
  logic          alarm;
  logic [TW-1:0] total_count;
  logic          busy;

  modport master (
    output en, hit, clr_alarm,
    input  frame_done, frame_count, alarm, total_count, busy
  );

  modport slave (
    input  en, hit, clr_alarm,
    output frame_done, frame_count, alarm, total_count, busy
  );
endinterface

// File: rtl/det_event_monitor.sv
// Frame-based hit counter for the serial pattern detector output: per-frame hit
// count, sticky threshold alarm and a saturating running total of hits.
module det_event_monitor #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned THRESH    = 3,
  parameter int unsigned TW        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  det_event_monitor_if.slave    bus
);
  localparam int unsigned CW  = $clog2(FRAME_LEN + 1);
  localparam int unsigned CCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned TW1 = TW + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [CCW-1:0] cyc_q, cyc_d;
  logic [CW-1:0]  hit_q, hit_d;
  logic           frame_done_q, frame_done_d;
  logic [CW-1:0]  frame_count_q, frame_count_d;
  logic           alarm_q, alarm_d;
  logic [TW-1:0]  total_q, total_d;
  logic           busy_q, busy_d;

  logic [CW-1:0]  frame_sum;
  logic [TW1-1:0] total_sum;
  logic           frame_end;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cyc_q         <= '0;
      hit_q         <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      alarm_q       <= 1'b0;
      total_q       <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      hit_q         <= hit_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      alarm_q       <= alarm_d;
      total_q       <= total_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state, counters and output updates
  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    hit_d         = hit_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    alarm_d       = alarm_q;
    total_d       = total_q;
    frame_end     = 1'b0;

    // The current cycle's hit is folded in so the last cycle of a frame counts.
    frame_sum = hit_q + CW'(bus.hit);
    total_sum = {1'b0, total_q} + TW1'(frame_sum);

    case (state_q)
      IDLE: begin
        cyc_d = '0;
        hit_d = '0;
        if (bus.en) begin
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (!bus.en) begin
          state_d = IDLE;
          cyc_d   = '0;
          hit_d   = '0;
        end else if (cyc_q == CCW'(FRAME_LEN - 1)) begin
          frame_end     = 1'b1;
          cyc_d         = '0;
          hit_d         = '0;
          frame_done_d  = 1'b1;
          frame_count_d = frame_sum;
          total_d       = total_sum[TW] ? {TW{1'b1}} : total_sum[TW-1:0];
        end else begin
          cyc_d = CCW'(cyc_q + 1'b1);
          hit_d = frame_sum;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = '0;
        hit_d   = '0;
      end
    endcase

    // A setting frame end beats a simultaneous clear request.
    if (frame_end && (frame_sum >= CW'(THRESH))) begin
      alarm_d = 1'b1;
    end else if (bus.clr_alarm) begin
      alarm_d = 1'b0;
    end

    busy_d = (state_d == COUNT);
  end

  assign bus.frame_done  = frame_done_q;
  assign bus.frame_count = frame_count_q;
  assign bus.alarm       = alarm_q;
  assign bus.total_count = total_q;
  assign bus.busy        = busy_q;
endmodule
